rf_ram_arb: RTL and testbench
=============================

// Module: rf_ram_arb
// PURPOSE
//  Responder side of the register-file RAM interface. Owns the RF row storage and
//  serves two initiators: port 0 (the RF move engine, fixed priority, never stalled)
//  and port 1 (host/DMA, req/gnt handshake). One access per cycle; 1-cycle read latency.
// PARAMETERS
//  WIDTH      1408  row width in bits (176 bytes)
//  ADDR_W     9     row address width; DEPTH = 2**ADDR_W rows
//  STALL_CW   16    width of saturating port-1 stall counter
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        reset, asynchronous, active-low
//  p0_addr       in   ADDR_W   port-0 row address
//  p0_re         in   1        port-0 read strobe (single cycle)
//  p0_we         in   1        port-0 write strobe (single cycle)
//  p0_d          in   WIDTH    port-0 write data
//  p0_q          out  WIDTH    port-0 read data, valid cycle after p0_re, then held
//  p1_req        in   1        port-1 request; addr/we/d held stable until p1_gnt
//  p1_we         in   1        port-1 op: 1 = write, 0 = read
//  p1_addr       in   ADDR_W   port-1 row address
//  p1_d          in   WIDTH    port-1 write data
//  p1_gnt        out  1        port-1 request accepted this cycle (combinational)
//  p1_rvalid     out  1        one-cycle pulse: p1_q carries read data
//  p1_q          out  WIDTH    port-1 read data, held until next port-1 read returns
//  p0_conflict   out  1        sticky: p0_re and p0_we seen in the same cycle
//  p1_stall_cnt  out  STALL_CW saturating count of cycles p1_req denied
// BEHAVIOUR
//  - Reset: p0_q=0, p1_q=0, p1_rvalid=0, p0_conflict=0, p1_stall_cnt=0, internal
//    read-owner tag=NONE. RAM contents not reset (undefined until written).
//  - Arbitration each cycle: p0_act = p0_re|p0_we. If p0_act, port 0 drives RAM;
//    p1_gnt=0. Else p1_gnt = p1_req and port 1 drives RAM. p1_gnt never asserted
//    without p1_req.
//  - p0_we & p0_re together: write performed, read dropped, p0_q unchanged,
//    p0_conflict set (cleared only by reset).
//  - Writes: row at addr takes d at the clock edge of the accepted cycle. A read of
//    the same row on the following cycle returns the new data.
//  - Reads: RAM output registered; owner tag (NONE/P0/P1) registered with the
//    access. Cycle N+1 after accept: tag P0 -> p0_q <= ram_q; tag P1 -> p1_q <= ram_q
//    and p1_rvalid=1. Other port's q holds. Back-to-back reads allowed every cycle.
//  - p1 read/write accepted in the same cycle as a p0 access: impossible by
//    arbitration; port-1 initiator sees p1_gnt=0 and retries next cycle.
//  - p1_stall_cnt: +1 each cycle p1_req & ~p1_gnt; saturates at all-ones.
//  - Reset asserted mid-read: pending return discarded; no p1_rvalid after release.
//  - Port 0 contract: re/we are single-cycle strobes; data captured by initiator in
//    the cycle after re (p0_q also holds afterwards, so later capture is valid).
// STRUCTURE
//  - rf_pkg (shared): RF_WIDTH=1408, RF_ADDR_W=9, typedef rf_addr_t, rf_row_t,
//    enum logic[1:0] rd_owner_t {OWN_NONE, OWN_P0, OWN_P1}.
//  - Sub-module rf_ram_sp: single-port sync RAM (addr, we, re, d, q registered,
//    q holds when re=0); inferable, swappable for a macro. Arbiter, owner tag,
//    q hold registers, stall counter and conflict flag live in this module.
// TESTING
//  - p0 write row 5 = A; next cycle p0_re row 5 -> p0_q==A on following cycle, held
//    4 more idle cycles.
//  - Move pattern: p0_re row 3 (=B), then p0_we row 7 with d=p0_q -> p1 read row 7
//    returns B with one p1_rvalid pulse.
//  - p1_req read row 9 held while p0 active 3 cycles -> p1_gnt on 4th cycle,
//    p1_rvalid next cycle, p1_stall_cnt==3, p0_q untouched.
//  - Alternating p0 read / p1 read every cycle -> each q updates only from its own
//    reads; no lost or swapped data.
//  - p0_re=p0_we=1 on row 2 d=C -> row 2 reads C, p0_q unchanged, p0_conflict=1
//    until rst_n low.
//  - Assert rst_n low the cycle after p1 read grant -> p1_rvalid stays 0, all
//    outputs 0; p1_req held 2^STALL_CW+2 cycles under p0 load -> counter saturates.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file RAM types: row geometry and the read-owner tag that
// steers registered RAM read data back to the port that issued the read.
package rf_pkg;

  localparam int unsigned RF_WIDTH  = 1408;
  localparam int unsigned RF_ADDR_W = 9;
  localparam int unsigned RF_DEPTH  = 2 ** RF_ADDR_W;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_WIDTH-1:0]  rf_row_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } rd_owner_t;

  // Owner of the read issued this cycle; at most one of the inputs is set.
  function automatic rd_owner_t rd_owner(input logic p0_rd, input logic p1_rd);
    if (p0_rd) begin
      return OWN_P0;
    end else if (p1_rd) begin
      return OWN_P1;
    end
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/rf_ram_sp.sv
// Single-port synchronous RAM for RF rows. Registered read data holds while
// re_i is low. Written in the inferable style so a macro can replace it.
module rf_ram_sp
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH  = RF_WIDTH,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [WIDTH-1:0]  d_i,
  output logic [WIDTH-1:0]  q_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] q_q;

  // Array write and registered read; no reset so the array maps onto RAM cells.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= d_i;
    end
    if (re_i) begin
      q_q <= mem[addr_i];
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/rf_ram_arb.sv
// Register-file RAM responder. Port 0 (move engine) always wins the single RAM
// port; port 1 (host/DMA) is granted only in cycles where port 0 is idle.
// Read data is steered back by an owner tag that travels with the access.
module rf_ram_arb
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_WIDTH,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic                p0_re,
  input  logic                p0_we,
  input  logic [WIDTH-1:0]    p0_d,
  output logic [WIDTH-1:0]    p0_q,
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [WIDTH-1:0]    p1_d,
  output logic                p1_gnt,
  output logic                p1_rvalid,
  output logic [WIDTH-1:0]    p1_q,
  output logic                p0_conflict,
  output logic [STALL_CW-1:0] p1_stall_cnt
);

  localparam logic [STALL_CW-1:0] StallMax = {STALL_CW{1'b1}};

  logic              p0_act;
  logic              p0_rd;
  logic              p1_rd;
  logic              p1_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_re;
  logic [WIDTH-1:0]  ram_d;
  logic [WIDTH-1:0]  ram_q;

  rd_owner_t         owner_d, owner_q;
  logic [WIDTH-1:0]  p0_hold_d, p0_hold_q;
  logic [WIDTH-1:0]  p1_hold_d, p1_hold_q;
  logic              conflict_d, conflict_q;
  logic [STALL_CW-1:0] stall_d, stall_q;

  // Fixed-priority arbitration and RAM port mux.
  always_comb begin
    p0_act   = p0_re | p0_we;
    p1_gnt   = p1_req & ~p0_act;
    // A simultaneous p0 read+write keeps the write and drops the read.
    p0_rd    = p0_re & ~p0_we;
    p1_rd    = p1_gnt & ~p1_we;
    p1_wr    = p1_gnt & p1_we;
    ram_addr = p0_act ? p0_addr : p1_addr;
    ram_d    = p0_act ? p0_d : p1_d;
    ram_we   = p0_we | p1_wr;
    ram_re   = p0_rd | p1_rd;
  end

  rf_ram_sp #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .addr_i (ram_addr),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .d_i    (ram_d),
    .q_o    (ram_q)
  );

  // Next state: owner tag, per-port hold registers, sticky flag, stall counter.
  always_comb begin
    owner_d    = rd_owner(p0_rd, p1_rd);
    p0_hold_d  = p0_hold_q;
    p1_hold_d  = p1_hold_q;
    conflict_d = conflict_q | (p0_re & p0_we);
    stall_d    = stall_q;

    // Capture the returning row so the owning port keeps it after ram_q moves on.
    unique case (owner_q)
      OWN_P0:  p0_hold_d = ram_q;
      OWN_P1:  p1_hold_d = ram_q;
      default: ;
    endcase

    if (p1_req && !p1_gnt && (stall_q != StallMax)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Outputs: the owning port sees ram_q directly in the return cycle, giving
  // one-cycle latency; otherwise it sees its own held copy.
  always_comb begin
    p0_q         = (owner_q == OWN_P0) ? ram_q : p0_hold_q;
    p1_q         = (owner_q == OWN_P1) ? ram_q : p1_hold_q;
    p1_rvalid    = (owner_q == OWN_P1);
    p0_conflict  = conflict_q;
    p1_stall_cnt = stall_q;
  end

  // State registers; reset clears the owner tag so an in-flight read is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_NONE;
      p0_hold_q  <= '0;
      p1_hold_q  <= '0;
      conflict_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      owner_q    <= owner_d;
      p0_hold_q  <= p0_hold_d;
      p1_hold_q  <= p1_hold_d;
      conflict_q <= conflict_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_rf_ram_arb.sv
// Bench for rf_ram_arb: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the row store.
module tb_rf_ram_arb;

  localparam int unsigned W         = 1408;
  localparam int unsigned AW        = 9;
  localparam int unsigned SCW       = 10;
  localparam int unsigned DEPTH     = 2 ** AW;
  localparam int unsigned STALL_MAX = (1 << SCW) - 1;

  logic           clk;
  logic           rst_n;
  logic [AW-1:0]  p0_addr;
  logic           p0_re;
  logic           p0_we;
  logic [W-1:0]   p0_d;
  logic [W-1:0]   p0_q;
  logic           p1_req;
  logic           p1_we;
  logic [AW-1:0]  p1_addr;
  logic [W-1:0]   p1_d;
  logic           p1_gnt;
  logic           p1_rvalid;
  logic [W-1:0]   p1_q;
  logic           p0_conflict;
  logic [SCW-1:0] p1_stall_cnt;

  rf_ram_arb #(
    .WIDTH    (W),
    .ADDR_W   (AW),
    .STALL_CW (SCW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_addr      (p0_addr),
    .p0_re        (p0_re),
    .p0_we        (p0_we),
    .p0_d         (p0_d),
    .p0_q         (p0_q),
    .p1_req       (p1_req),
    .p1_we        (p1_we),
    .p1_addr      (p1_addr),
    .p1_d         (p1_d),
    .p1_gnt       (p1_gnt),
    .p1_rvalid    (p1_rvalid),
    .p1_q         (p1_q),
    .p0_conflict  (p0_conflict),
    .p1_stall_cnt (p1_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] m_p0_q;
  logic [W-1:0] m_p1_q;
  bit           m_rvalid;
  bit           m_conf;
  int unsigned  m_stall;

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    int fb;
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      fb = -1;
      for (int i = 0; i < int'(W); i++) begin
        if (got[i] !== exp[i]) begin
          fb = i;
          break;
        end
      end
      $display("FAIL %s: got[63:0]=%h want[63:0]=%h first_diff_bit=%0d",
               tag, got[63:0], exp[63:0], fb);
    end
  endtask

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic model_reset();
    m_p0_q   = '0;
    m_p1_q   = '0;
    m_rvalid = 0;
    m_conf   = 0;
    m_stall  = 0;
  endtask

  // One accepted clock edge, expressed as what each port asked for.
  task automatic model_edge();
    bit act;
    bit g;
    act = p0_re || p0_we;
    g   = !act && p1_req;
    if (p0_re && !p0_we) m_p0_q = mem[p0_addr];
    m_rvalid = g && !p1_we;
    if (m_rvalid) m_p1_q = mem[p1_addr];
    if (p0_we) mem[p0_addr] = p0_d;
    else if (g && p1_we) mem[p1_addr] = p1_d;
    if (p0_re && p0_we) m_conf = 1;
    if (p1_req && !g && m_stall != STALL_MAX) m_stall++;
  endtask

  task automatic check_all();
    check("p1_gnt", p1_gnt, p1_req && !(p0_re || p0_we));
    check("p0_q", p0_q, m_p0_q);
    check("p1_q", p1_q, m_p1_q);
    check("p1_rvalid", p1_rvalid, m_rvalid);
    check("p0_conflict", p0_conflict, m_conf);
    check("p1_stall_cnt", p1_stall_cnt, m_stall);
  endtask

  // Check mid-cycle, then advance the model with the DUT on the edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    p0_re   = 0;
    p0_we   = 0;
    p0_addr = '0;
    p0_d    = '0;
    p1_req  = 0;
    p1_we   = 0;
    p1_addr = '0;
    p1_d    = '0;
  endtask

  // Entered at posedge+1; leaves at posedge+1 with reset released.
  task automatic do_reset();
    idle();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic p0_write(input int a, input logic [W-1:0] d);
    p0_addr = AW'(a);
    p0_d    = d;
    p0_we   = 1;
    cycle();
    p0_we   = 0;
  endtask

  task automatic p0_read(input int a);
    p0_addr = AW'(a);
    p0_re   = 1;
    cycle();
    p0_re   = 0;
  endtask

  logic [W-1:0] val_a, val_b, val_c, prev;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    for (int a = 0; a < 16; a++) p0_write(a, rand_row());

    // Write then read-back on port 0, with hold.
    val_a = rand_row();
    p0_write(5, val_a);
    p0_read(5);
    check("t1_p0_q", p0_q, val_a);
    repeat (4) begin
      cycle();
      check("t1_p0_hold", p0_q, val_a);
    end

    // Move pattern: read row 3, write its data to row 7, host reads row 7.
    val_b = rand_row();
    p0_write(3, val_b);
    p0_read(3);
    p0_addr = 7;
    p0_d    = p0_q;
    p0_we   = 1;
    cycle();
    p0_we   = 0;
    p1_req  = 1;
    p1_we   = 0;
    p1_addr = 7;
    cycle();
    p1_req  = 0;
    check("t2_rvalid", p1_rvalid, 1'b1);
    check("t2_p1_q", p1_q, val_b);
    cycle();
    check("t2_rvalid_pulse", p1_rvalid, 1'b0);

    // Host read stalled by three port-0 writes.
    p0_write(9, rand_row());
    val_c = mem[9];
    do_reset();
    p1_req  = 1;
    p1_we   = 0;
    p1_addr = 9;
    for (int i = 0; i < 3; i++) begin
      p0_we   = 1;
      p0_addr = AW'(10 + i);
      p0_d    = rand_row();
      #1;
      check("t3_no_gnt", p1_gnt, 1'b0);
      cycle();
    end
    p0_we = 0;
    #1;
    check("t3_gnt", p1_gnt, 1'b1);
    cycle();
    p1_req = 0;
    check("t3_rvalid", p1_rvalid, 1'b1);
    check("t3_p1_q", p1_q, val_c);
    check("t3_stall", p1_stall_cnt, 3);
    check("t3_p0_q", p0_q, '0);
    cycle();

    // Alternating port-0 and port-1 reads.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        p0_re   = 1;
        p0_addr = AW'($urandom_range(0, 15));
      end else begin
        p1_req  = 1;
        p1_we   = 0;
        p1_addr = AW'($urandom_range(0, 15));
      end
      cycle();
      p0_re  = 0;
      p1_req = 0;
    end
    cycle();

    // Simultaneous read+write on port 0.
    val_c   = rand_row();
    prev    = m_p0_q;
    p0_addr = 2;
    p0_d    = val_c;
    p0_re   = 1;
    p0_we   = 1;
    cycle();
    p0_re   = 0;
    p0_we   = 0;
    check("t5_conflict", p0_conflict, 1'b1);
    check("t5_p0_q_kept", p0_q, prev);
    p0_read(2);
    check("t5_row2", p0_q, val_c);
    repeat (3) cycle();
    check("t5_sticky", p0_conflict, 1'b1);

    // Reset in the cycle after a host read grant.
    p1_req  = 1;
    p1_we   = 0;
    p1_addr = 4;
    cycle();
    do_reset();
    check("t6_conflict_clr", p0_conflict, 1'b0);
    check("t6_p1_q", p1_q, '0);
    repeat (2) begin
      cycle();
      check("t6_no_rvalid", p1_rvalid, 1'b0);
    end

    // Stall counter saturation under continuous port-0 load.
    p1_req  = 1;
    p1_we   = 0;
    p1_addr = 1;
    for (int i = 0; i < int'((1 << SCW) + 2); i++) begin
      p0_re   = 1;
      p0_addr = AW'($urandom_range(0, 15));
      cycle();
    end
    check("t7_saturated", p1_stall_cnt, STALL_MAX);
    p0_re = 0;
    cycle();
    p1_req = 0;
    cycle();

    // Randomized mixed traffic with a held port-1 handshake.
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit granted;
      r       = $urandom_range(0, 99);
      p0_re   = (r < 30);
      p0_we   = (r >= 25 && r < 50);
      p0_addr = AW'($urandom_range(0, 15));
      p0_d    = rand_row();
      if (!p1_req && $urandom_range(0, 1) == 1) begin
        p1_req  = 1;
        p1_we   = $urandom_range(0, 1) == 1;
        p1_addr = AW'($urandom_range(0, 15));
        p1_d    = rand_row();
      end
      granted = p1_req && !(p0_re || p0_we);
      cycle();
      if (granted) p1_req = 0;
    end
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
